// File: rtl/demorgan_checker_if.sv
// Stimulus/response bundle between the De Morgan sweep checker and its environment.
// The checker side is the master; the DUT/test harness side is the slave.
interface demorgan_checker_if;
    logic       start;
    logic [7:0] dut_vec;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [7:0] fail_bits;
    logic [2:0] fail_count;

    modport master (
        input  start,
        input  dut_vec,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output fail_mask,
        output fail_bits,
        output fail_count
    );

    modport slave (
        output start,
        output dut_vec,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask,
        input  fail_bits,
        input  fail_count
    );
endinterface

// File: rtl/demorgan_checker.sv
// Sweeps {a,b} through 00..11, lets the DUT settle, and compares its eight
// gate outputs against the De Morgan truth table, accumulating a fail summary.
module demorgan_checker #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demorgan_checker_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    state_t     state_nx;
    logic [1:0] idx;
    logic [1:0] idx_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [1:0] ab;
    logic [1:0] ab_nx;
    logic       done_q;
    logic       done_nx;
    logic       pass_q;
    logic       pass_nx;
    logic [3:0] mask_q;
    logic [3:0] mask_nx;
    logic [7:0] bits_q;
    logic [7:0] bits_nx;
    logic [2:0] count_q;
    logic [2:0] count_nx;
    logic [7:0] diff;

    // Bit order {nAornB,nAandB,AandB,nAorB,AorB,nAandnB,nB,nA}
    function automatic logic [7:0] expected_vec(input logic [1:0] i);
        logic [7:0] v;
        v = 8'h00;
        unique case (i)
            2'd0: v = 8'hD7;
            2'd1: v = 8'hC9;
            2'd2: v = 8'hCA;
            2'd3: v = 8'h28;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        ab_nx    = ab;
        done_nx  = 1'b0;
        pass_nx  = pass_q;
        mask_nx  = mask_q;
        bits_nx  = bits_q;
        count_nx = count_q;
        diff     = bus.dut_vec ^ expected_vec(idx);

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = SETTLE;
                    idx_nx   = 2'd0;
                    ab_nx    = 2'd0;
                    cnt_nx   = CNT_LOAD;
                    pass_nx  = 1'b0;
                    mask_nx  = 4'd0;
                    bits_nx  = 8'd0;
                    count_nx = 3'd0;
                end
            end
            SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_nx = cnt - 4'd1;
                end else begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (diff != 8'd0) begin
                    mask_nx[idx] = 1'b1;
                    bits_nx      = bits_q | diff;
                    if (count_q != 3'd4) begin
                        count_nx = count_q + 3'd1;
                    end
                end
                if (idx != 2'd3) begin
                    idx_nx   = idx + 2'd1;
                    ab_nx    = idx + 2'd1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = SETTLE;
                end else begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                // count_q already holds the last vector's update here
                done_nx  = 1'b1;
                pass_nx  = (count_q == 3'd0);
                ab_nx    = 2'd0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= 2'd0;
            cnt     <= 4'd0;
            ab      <= 2'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 4'd0;
            bits_q  <= 8'd0;
            count_q <= 3'd0;
        end else begin
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            ab      <= ab_nx;
            done_q  <= done_nx;
            pass_q  <= pass_nx;
            mask_q  <= mask_nx;
            bits_q  <= bits_nx;
            count_q <= count_nx;
        end
    end

    assign bus.a          = ab[1];
    assign bus.b          = ab[0];
    assign bus.busy       = (state == SETTLE) || (state == SAMPLE);
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail_mask  = mask_q;
    assign bus.fail_bits  = bits_q;
    assign bus.fail_count = count_q;

endmodule

// File: tb/tb_demorgan_checker.sv
// Scoreboard bench: sweeps are queued with hand-computed results and a
// per-instance monitor checks each done pulse against the queue head.
module tb_demorgan_checker;

    typedef struct packed {
        logic [31:0] edge_no;
        logic        pass;
        logic [3:0]  mask;
        logic [7:0]  bits;
        logic [2:0]  count;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int          fault;
    int unsigned cyc;
    int          errors;
    int          checks;

    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        e0;
    exp_t        e1;
    logic [1:0]  ab_log[$];
    logic [7:0]  seq;

    demorgan_checker_if bus ();
    demorgan_checker_if bus0 ();

    demorgan_checker #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    demorgan_checker #(.SETTLE_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.master)
    );

    // Behavioural gate DUT with optional planted faults
    function automatic logic [7:0] gates(input logic x, input logic y,
                                         input int f);
        logic [7:0] v;
        v = {~x | ~y, ~(x & y), x & y, ~(x | y),
             x | y, ~x & ~y, ~y, ~x};
        if (f == 1) v[7] = 1'b0;
        if (f == 2) v[5] = ~v[5];
        return v;
    endfunction

    // Garbage while idle: must never be sampled
    assign bus.dut_vec  = bus.busy ? gates(bus.a, bus.b, fault) : 8'h00;
    assign bus0.dut_vec = bus0.busy ? gates(bus0.a, bus0.b, 0) : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ab_log.delete();
        end else begin
            if (bus.busy && (ab_log.size() == 0 ||
                             ab_log[$] != {bus.a, bus.b}))
                ab_log.push_back({bus.a, bus.b});
            if (bus.done) begin
                if (q0.size() == 0) begin
                    check("unexpected_done", {31'd0, bus.done}, 32'd0);
                end else begin
                    e0 = q0.pop_front();
                    seq = (ab_log.size() == 4) ?
                          {ab_log[0], ab_log[1], ab_log[2], ab_log[3]} :
                          8'hFF;
                    check("latency", cyc, e0.edge_no);
                    check("pass", {31'd0, bus.pass}, {31'd0, e0.pass});
                    check("fail_mask", {28'd0, bus.fail_mask},
                          {28'd0, e0.mask});
                    check("fail_bits", {24'd0, bus.fail_bits},
                          {24'd0, e0.bits});
                    check("fail_count", {29'd0, bus.fail_count},
                          {29'd0, e0.count});
                    check("ab_seq", {24'd0, seq}, 32'h1B);
                    check("ab_after_done", {30'd0, bus.a, bus.b}, 32'd0);
                end
                ab_log.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus0.done) begin
            if (q1.size() == 0) begin
                check("unexpected_done0", {31'd0, bus0.done}, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("latency0", cyc, e1.edge_no);
                check("pass0", {31'd0, bus0.pass}, {31'd0, e1.pass});
                check("fail_count0", {29'd0, bus0.fail_count},
                      {29'd0, e1.count});
            end
        end
    end

    task automatic push0(input logic [31:0] edge_no, input logic p,
                         input logic [3:0] m, input logic [7:0] b,
                         input logic [2:0] c);
        exp_t e;
        e.edge_no = edge_no;
        e.pass    = p;
        e.mask    = m;
        e.bits    = b;
        e.count   = c;
        q0.push_back(e);
    endtask

    task automatic run0(input int f, input logic p, input logic [3:0] m,
                        input logic [7:0] b, input logic [2:0] c);
        @(negedge clk);
        fault     = f;
        bus.start = 1'b1;
        push0(cyc + 1 + 17, p, m, b, c);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q0.size() + q1.size()) != 0; i++)
            @(negedge clk);
        check("drain", q0.size() + q1.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int unsigned s;
        errors    = 0;
        checks    = 0;
        fault     = 0;
        bus.start  = 1'b0;
        bus0.start = 1'b0;
        rst_n     = 1'b1;
        #3 rst_n  = 1'b0;
        #1;
        check("reset_outs", {12'd0, bus.a, bus.b, bus.busy, bus.done,
              bus.pass, bus.fail_mask, bus.fail_bits, bus.fail_count},
              32'd0);
        check("reset_outs0", {12'd0, bus0.a, bus0.b, bus0.busy, bus0.done,
              bus0.pass, bus0.fail_mask, bus0.fail_bits, bus0.fail_count},
              32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run0(0, 1'b1, 4'b0000, 8'h00, 3'd0);
        drain();
        run0(1, 1'b0, 4'b0111, 8'h80, 3'd3);
        drain();
        run0(2, 1'b0, 4'b1111, 8'h20, 3'd4);
        drain();

        repeat (5) @(negedge clk);
        check("hold_results", {15'd0, bus.pass, bus.fail_mask,
              bus.fail_bits, bus.fail_count}, {15'd0, 1'b0, 4'hF,
              8'h20, 3'd4});

        // Abort during idx=2 SETTLE
        @(negedge clk);
        fault     = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("ab_idx2", {30'd0, bus.a, bus.b}, 32'd2);
        check("busy_idx2", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid", {12'd0, bus.a, bus.b, bus.busy, bus.done,
              bus.pass, bus.fail_mask, bus.fail_bits, bus.fail_count},
              32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        run0(0, 1'b1, 4'b0000, 8'h00, 3'd0);
        drain();

        // start held high for 40 cycles: sweeps at +0, +18, +36
        @(negedge clk);
        fault     = 0;
        bus.start = 1'b1;
        s = cyc + 1;
        push0(s + 17, 1'b1, 4'd0, 8'd0, 3'd0);
        push0(s + 35, 1'b1, 4'd0, 8'd0, 3'd0);
        push0(s + 53, 1'b1, 4'd0, 8'd0, 3'd0);
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        drain();

        // Zero settle cycles
        @(negedge clk);
        bus0.start = 1'b1;
        e.edge_no  = cyc + 1 + 9;
        e.pass     = 1'b1;
        e.mask     = 4'd0;
        e.bits     = 8'd0;
        e.count    = 3'd0;
        q1.push_back(e);
        @(negedge clk);
        bus0.start = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
